// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding and default geometry for the direct-mapped cache responder
package cache_pkg;
   localparam int DEF_ADDR_W  = 12;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_INDEX_W = 4;
   localparam int DEF_TAG_W   = DEF_ADDR_W - DEF_INDEX_W;
   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: valid/tag/data storage, one combinational read port, one synchronous write port
module cache_line_array #(
   parameter int INDEX_W = 4,
   parameter int TAG_W   = 8,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] rd_index,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [DATA_W-1:0]  rd_data,
   input  logic               we,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [DATA_W-1:0]  wr_data
);
   localparam int LINES = 1 << INDEX_W;
   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tag_ram  [LINES];
   logic [DATA_W-1:0] data_ram [LINES];
   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_ram[rd_index];
   assign rd_data  = data_ram[rd_index];
   // valid bits are the only state that reset must clear
   always_ff @(posedge clk) begin
      if (rst) valid <= '0;
      else if (we) valid[wr_index] <= 1'b1;
   end
   // tag and data are meaningless until valid is set, so they carry no reset
   always_ff @(posedge clk) begin
      if (we) begin
         tag_ram[wr_index]  <= wr_tag;
         data_ram[wr_index] <= wr_data;
      end
   end
endmodule

// File: rtl/cache_dm_responder.sv
// cache_dm_responder: direct-mapped write-through no-write-allocate cache, CPU responder with req/ack memory port
// Optional hit/miss counters enabled by defining CACHE_STATS_EN.
module cache_dm_responder
   import cache_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int INDEX_W = DEF_INDEX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r_en,
   input  logic              w_en,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   output logic              stall,
   output logic [DATA_W-1:0] saida_cache,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
`endif
);
   localparam int TAG_W = ADDR_W - INDEX_W;
   state_t              state;
   logic                line_valid, hit, we;
   logic [TAG_W-1:0]    line_tag, wr_tag;
   logic [DATA_W-1:0]   line_data, wr_data;
   logic [INDEX_W-1:0]  wr_index;
   wire  [INDEX_W-1:0]  idx = address[INDEX_W-1:0];
   wire  [TAG_W-1:0]    tag = address[ADDR_W-1:INDEX_W];
   cache_line_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_lines (
      .clk(clk), .rst(rst), .rd_index(idx), .rd_valid(line_valid), .rd_tag(line_tag),
      .rd_data(line_data), .we(we), .wr_index(wr_index), .wr_tag(wr_tag), .wr_data(wr_data)
   );
   // refill writes from the latched miss address; a write hit updates the line in place
   always_comb begin
      hit      = line_valid && line_tag == tag;
      stall    = state != IDLE || w_en || (r_en && !hit);
      we       = (state == IDLE && w_en && hit) || (state == FILL && mem_ack);
      wr_index = state == FILL ? mem_addr[INDEX_W-1:0] : idx;
      wr_tag   = state == FILL ? mem_addr[ADDR_W-1:INDEX_W] : tag;
      wr_data  = state == FILL ? mem_rdata : data;
   end
   // request FSM: writes win over reads, misses fill from memory, writes go through
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         saida_cache <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_rd      <= 1'b0;
         mem_wr      <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (w_en) begin
                  mem_addr  <= address;
                  mem_wdata <= data;
                  mem_wr    <= 1'b1;
                  state     <= WRITE;
               end else if (r_en && hit) saida_cache <= line_data;
               else if (r_en) begin
                  mem_addr <= address;
                  mem_rd   <= 1'b1;
                  state    <= FILL;
               end
            FILL:
               if (mem_ack) begin
                  saida_cache <= mem_rdata;
                  mem_rd      <= 1'b0;
                  state       <= IDLE;
               end
            WRITE:
               if (mem_ack) begin
                  mem_wr <= 1'b0;
                  state  <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef CACHE_STATS_EN
   // saturating counters of completed read hits and completed read refills
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (state == IDLE && r_en && !w_en && hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
         if (state == FILL && mem_ack && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
   end
`endif
endmodule
